multicycle_ctrl: RTL

Main control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback around the decode stage, the ALU and the register file. It drives the instruction-memory and data-memory request/ready handshakes, the PC, IR and register-file write enables, and the PC and writeback source selects. It also detects trap/halt conditions and keeps the cycle and retired-instruction counters.

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM of the multi-cycle RV32I core.
//
// Sequences fetch, decode, execute, memory and writeback. It drives the
// instruction/data memory handshakes, the PC/IR/register-file write enables
// and the PC/writeback source selects. It detects trap/halt conditions and
// keeps the cycle and retired-instruction counters.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   imem_req / imem_ready     instruction fetch handshake
//   ir_wen                    latch fetched instruction into IR
//   dec_inst_type, dec_rd_wen, dec_ebreak   decoder results (sampled in DECODE)
//   branch_taken              ALU branch compare (sampled in EXEC)
//   dmem_req / dmem_we / dmem_ready         data memory handshake
//   pc_wen, pc_sel            PC update, 0 = pc+4, 1 = branch/jump target
//   rf_wen, rf_wdata_sel      register write, 0 = ALU, 1 = load data, 2 = pc+4
//   halt, trap_good           sticky stop, 1 = EBREAK / 0 = bad trap
//   cycle_cnt, instret_cnt    free-running counters (frozen in HALT)
//   state                     current FSM state (debug)
//
// state  | meaning
// FETCH  | request instruction until imem_ready, then write IR
// DECODE | capture decoder class/rd_wen, trap on NO_TYPE / ZICSR
// EXEC   | capture branch result, choose MEM or WB
// MEM    | data access until dmem_ready (loads and stores only)
// WB     | write PC and register file, retire
// HALT   | stopped until reset
// 6, 7   | illegal, fall into HALT as a bad trap

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_wen,
  input  logic [3:0]       dec_inst_type,
  input  logic             dec_rd_wen,
  input  logic             dec_ebreak,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_wen,
  output logic             pc_sel,
  output logic             rf_wen,
  output logic [1:0]       rf_wdata_sel,
  output logic             halt,
  output logic             trap_good,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [2:0]       state
);

  // Instruction class encodings shared with the decoder.
  localparam logic [3:0] T_R     = 4'd0;
  localparam logic [3:0] T_I     = 4'd1;
  localparam logic [3:0] T_L     = 4'd2;
  localparam logic [3:0] T_S     = 4'd3;
  localparam logic [3:0] T_B     = 4'd4;
  localparam logic [3:0] T_J     = 4'd5;
  localparam logic [3:0] T_JALR  = 4'd6;
  localparam logic [3:0] T_LUI   = 4'd7;
  localparam logic [3:0] T_AUIPC = 4'd8;
  localparam logic [3:0] T_ZICSR = 4'd9;
  localparam logic [3:0] T_FENCE = 4'd10;
  localparam logic [3:0] T_NONE  = 4'd11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // The watchdog only needs to count up to MEM_TIMEOUT-1: the cycle that
  // would reach MEM_TIMEOUT is the one that halts.
  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          st;
  logic [WD_W-1:0] wd;
  logic [3:0]      ltype;
  logic            lrd_wen;
  logic            lbr;
  logic            wd_expire;

  assign wd_expire = (MEM_TIMEOUT != 0) && (wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_FETCH;
      wd          <= '0;
      ltype       <= T_NONE;
      lrd_wen     <= 1'b0;
      lbr         <= 1'b0;
      trap_good   <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      // Any cycle that does not explicitly keep counting clears the watchdog,
      // which covers both "ready seen" and "state changed".
      wd <= '0;
      if (st != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      case (st)
        S_FETCH: begin
          if (imem_ready) begin
            st <= S_DECODE;
          end else if (wd_expire) begin
            st        <= S_HALT;
            trap_good <= 1'b0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_DECODE: begin
          ltype   <= dec_inst_type;
          lrd_wen <= dec_rd_wen;
          if (dec_inst_type == T_NONE) begin
            st        <= S_HALT;
            trap_good <= 1'b0;
          end else if (dec_inst_type == T_ZICSR) begin
            st        <= S_HALT;
            trap_good <= dec_ebreak;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          lbr <= branch_taken;
          st  <= (ltype == T_L || ltype == T_S) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            st <= S_WB;
          end else if (wd_expire) begin
            st        <= S_HALT;
            trap_good <= 1'b0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_WB: begin
          instret_cnt <= instret_cnt + CNT_W'(1);
          st          <= S_FETCH;
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: begin
          st        <= S_HALT;
          trap_good <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    imem_req     = 1'b0;
    ir_wen       = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_wen       = 1'b0;
    pc_sel       = 1'b0;
    rf_wen       = 1'b0;
    rf_wdata_sel = 2'd0;
    halt         = 1'b0;
    case (st)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_wen   = imem_ready;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (ltype == T_S);
      end
      S_WB: begin
        pc_wen = 1'b1;
        pc_sel = (ltype == T_J) || (ltype == T_JALR) || ((ltype == T_B) && lbr);
        rf_wen = lrd_wen && !(ltype inside {T_S, T_B, T_FENCE});
        if (ltype == T_L)                          rf_wdata_sel = 2'd1;
        else if (ltype == T_J || ltype == T_JALR)  rf_wdata_sel = 2'd2;
        else                                       rf_wdata_sel = 2'd0;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = st;

  // Classes with no special control behaviour; named here so the encoding
  // table stays complete for readers.
  logic unused_types;
  assign unused_types = ^{T_R, T_I, T_LUI, T_AUIPC};

endmodule
